store_be_buffer: RTL and testbench

Parametrised store-path successor to the byte-enable data replicator in the MEM stage. It accepts committed stores from the MEM stage and detects misaligned addresses (AdES). It generates per-lane byte enables and lane-replicated write data, and queues stores in a DEPTH-entry FIFO. The FIFO drains to the data-memory / bridge port over a valid/ready handshake. The block sits between the MEM-stage store logic and the DM/bridge, and decouples pipeline progress from memory back-pressure.

---
 rtl/store_be_buffer.sv | 180 ++++++++++++++++++
 tb/tb_store_be_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_be_buffer.sv
// Store byte-enable buffer: aligns MEM-stage stores into lane-replicated data and byte enables, flags AdES, and queues them for the DM/bridge.
// Optional write combining into the tail entry is enabled with `define STORE_MERGE_EN.
module store_be_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [1:0]            st_size,
    input  logic [DATA_W-1:0]     st_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic                  exc_valid,
    output logic [ADDR_W-1:0]     exc_addr,
    input  logic [ADDR_W-1:0]     ld_addr,
    output logic                  ld_conflict,
    output logic                  idle
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [LANES-1:0]  be_q   [DEPTH];

    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              exc_valid_q;
    logic [ADDR_W-1:0] exc_addr_q;

    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] addr_mask;
    logic [ADDR_W-1:0] addr_new;
    logic [LANES-1:0]  be_new;
    logic [DATA_W-1:0] wdata_new;
    logic              misalign;
    logic              full, empty;
    logic              accept, fault, store, push, pop;

    assign off       = st_addr[OFF_W-1:0];
    assign addr_mask = ~ADDR_W'(LANES - 1);
    assign addr_new  = st_addr & addr_mask;

    // Alignment check; dword stores are illegal on a 32-bit datapath
    always_comb begin
        misalign = 1'b0;
        case (st_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = st_addr[0];
            2'd2:    misalign = |st_addr[1:0];
            default: misalign = (DATA_W == 32) ? 1'b1 : |st_addr[2:0];
        endcase
    end

    // Byte enables and lane replication of the raw register data
    always_comb begin
        be_new    = '0;
        wdata_new = '0;
        case (st_size)
            2'd0: begin
                be_new = LANES'(1) << off;
                for (int i = 0; i < LANES; i++) wdata_new[8*i +: 8] = st_data[7:0];
            end
            2'd1: begin
                be_new = LANES'(2'b11) << off;
                for (int i = 0; i < LANES / 2; i++) wdata_new[16*i +: 16] = st_data[15:0];
            end
            2'd2: begin
                be_new = LANES'(4'hF) << off;
                for (int i = 0; i < DATA_W / 32; i++) wdata_new[32*i +: 32] = st_data[31:0];
            end
            default: begin
                be_new    = '1;
                wdata_new = st_data;
            end
        endcase
    end

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign accept = st_valid && !full;
    assign fault  = accept && misalign;
    assign store  = accept && !misalign;
    assign pop    = !empty && mem_ready;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail;
    logic             merge;

    assign tail  = wr_q - PTR_W'(1);
    // A tail that is also the popping head cannot absorb new bytes
    assign merge = store && !empty && (addr_q[tail] == addr_new)
                   && !((cnt_q == CNT_W'(1)) && pop);
    assign push  = store && !merge;
`else
    assign push  = store;
`endif

    always_comb begin
        rd_d  = rd_q + PTR_W'(pop);
        wr_d  = wr_q + PTR_W'(push);
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            exc_valid_q <= fault;
            if (fault) exc_addr_q <= st_addr;
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else if (push) begin
            addr_q[wr_q] <= addr_new;
            data_q[wr_q] <= wdata_new;
            be_q[wr_q]   <= be_new;
        end
`ifdef STORE_MERGE_EN
        else if (merge) begin
            be_q[tail] <= be_q[tail] | be_new;
            for (int i = 0; i < LANES; i++) begin
                if (be_new[i]) data_q[tail][8*i +: 8] <= wdata_new[8*i +: 8];
            end
        end
`endif
    end

    // Load hazard: any occupied slot, including the one popping now
    always_comb begin
        logic [PTR_W-1:0] slot;
        ld_conflict = 1'b0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = PTR_W'(i) - rd_q;
            if ((CNT_W'(slot) < cnt_q) && (addr_q[i] == (ld_addr & addr_mask)))
                ld_conflict = 1'b1;
        end
    end

    assign st_ready  = !full;
    assign mem_valid = !empty;
    assign idle      = empty;
    assign mem_addr  = addr_q[rd_q];
    assign mem_wdata = data_q[rd_q];
    assign mem_be    = be_q[rd_q];
    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_store_be_buffer.sv
// Directed bench for store_be_buffer (DATA_W=32, DEPTH=4) with a queue-based reference model.
module tb_store_be_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic        clk, reset;
    logic        st_valid, st_ready;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_valid;
    logic [31:0] exc_addr;
    logic [31:0] ld_addr;
    logic        ld_conflict, idle;

    store_be_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_size(st_size), .st_data(st_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .exc_valid(exc_valid), .exc_addr(exc_addr),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    logic        m_exc_valid = 1'b0;
    logic [31:0] m_exc_addr  = 32'h0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic is_misal(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic ent_t make_ent(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        int   off;
        off    = int'(a % 4);
        e.addr = a - (a % 4);
        case (sz)
            2'd0:    begin e.be = 4'(1 << off);  e.data = {4{d[7:0]}};  end
            2'd1:    begin e.be = 4'(3 << off);  e.data = {2{d[15:0]}}; end
            default: begin e.be = 4'hF;          e.data = d;            end
        endcase
        return e;
    endfunction

    // Reference model: advances on each clock edge from the inputs presented
    always @(posedge clk or posedge reset) begin : model
        logic acc, pop, bad, merged;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_exc_valid = 1'b0;
            m_exc_addr  = 32'h0;
        end else begin
            acc    = st_valid && (mq.size() < DEPTH);
            pop    = (mq.size() != 0) && mem_ready;
            bad    = is_misal(st_size, st_addr);
            merged = 1'b0;
            e      = make_ent(st_size, st_addr, st_data);
            m_exc_valid = acc && bad;
            if (m_exc_valid) m_exc_addr = st_addr;
`ifdef STORE_MERGE_EN
            if (acc && !bad && mq.size() != 0 && mq[mq.size()-1].addr == e.addr
                && !(mq.size() == 1 && pop)) begin
                for (int i = 0; i < 4; i++)
                    if (e.be[i]) mq[mq.size()-1].data[8*i +: 8] = e.data[8*i +: 8];
                mq[mq.size()-1].be = mq[mq.size()-1].be | e.be;
                merged = 1'b1;
            end
`endif
            if (pop) void'(mq.pop_front());
            if (acc && !bad && !merged) mq.push_back(e);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin : compare
        logic hit;
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].addr == (ld_addr - (ld_addr % 4))) hit = 1'b1;
        chk("st_ready",    64'(st_ready),    64'(mq.size() < DEPTH));
        chk("mem_valid",   64'(mem_valid),   64'(mq.size() != 0));
        chk("idle",        64'(idle),        64'(mq.size() == 0));
        chk("exc_valid",   64'(exc_valid),   64'(m_exc_valid));
        chk("exc_addr",    64'(exc_addr),    64'(m_exc_addr));
        chk("ld_conflict", 64'(ld_conflict), 64'(hit));
        if (mq.size() != 0) begin
            chk("mem_addr",  64'(mem_addr),  64'(mq[0].addr));
            chk("mem_be",    64'(mem_be),    64'(mq[0].be));
            chk("mem_wdata", 64'(mem_wdata), 64'(mq[0].data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one store and hold it until the DUT takes it
    task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic ok;
        ok       = 1'b0;
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = st_ready;
            @(posedge clk);
            #1;
        end
        st_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        for (int k = 0; k < 50 && !idle; k++) @(negedge clk);
        chk("drained", 64'(idle), 64'd1);
        cyc();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int pops;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
        mem_ready = 1'b0; ld_addr = '0;

        repeat (2) @(negedge clk);
        chk("rst_st_ready",  64'(st_ready),  64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be",    64'(mem_be),    64'd0);
        chk("rst_exc_valid", 64'(exc_valid), 64'd0);
        chk("rst_exc_addr",  64'(exc_addr),  64'd0);
        chk("rst_idle",      64'(idle),      64'd1);
        cyc();
        reset = 1'b0;

        // Single byte store, one-cycle latency then pop
        mem_ready = 1'b1;
        send(2'd0, 32'h0000_1003, 32'h1234_56AB);
        @(negedge clk);
        chk("sb_valid", 64'(mem_valid), 64'd1);
        chk("sb_addr",  64'(mem_addr),  64'h1000);
        chk("sb_be",    64'(mem_be),    64'b1000);
        chk("sb_wdata", 64'(mem_wdata), 64'hABAB_ABAB);
        @(negedge clk);
        chk("sb_idle",  64'(idle),      64'd1);

        // Half store
        cyc();
        send(2'd1, 32'h0000_2002, 32'h0000_BEEF);
        @(negedge clk);
        chk("sh_be",    64'(mem_be),    64'b1100);
        chk("sh_wdata", 64'(mem_wdata), 64'hBEEF_BEEF);

        // Misaligned word: fault, nothing queued
        cyc();
        send(2'd2, 32'h0000_3001, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("ades_valid", 64'(exc_valid), 64'd1);
        chk("ades_addr",  64'(exc_addr),  64'h3001);
        chk("ades_noq",   64'(mem_valid), 64'd0);
        chk("ades_ready", 64'(st_ready),  64'd1);
        @(negedge clk);
        chk("ades_pulse", 64'(exc_valid), 64'd0);
        chk("ades_hold",  64'(exc_addr),  64'h3001);

        // Back-pressure: fill, stall a fifth, then drain
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd2, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
        @(negedge clk);
        chk("full_ready", 64'(st_ready), 64'd0);
        chk("full_head",  64'(mem_addr), 64'h100);
        cyc();
        fork
            send(2'd2, 32'h110, 32'hA4);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_addr",  64'(mem_addr),  64'h100);
                    chk("stall_wdata", 64'(mem_wdata), 64'hA0);
                    chk("stall_be",    64'(mem_be),    64'hF);
                end
                cyc();
                mem_ready = 1'b1;
            end
        join
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i % 2 == 0);
            send(2'd2, 32'h200 + 32'(4*i), 32'h1111 * 32'(i + 1));
        end
        drain();

        // Load conflict detection
        mem_ready = 1'b0;
        send(2'd2, 32'h0000_4000, 32'h55);
        ld_addr = 32'h0000_4002;
        @(negedge clk);
        chk("ldc_hit", 64'(ld_conflict), 64'd1);
        cyc();
        ld_addr = 32'h0000_4004;
        @(negedge clk);
        chk("ldc_miss", 64'(ld_conflict), 64'd0);
        cyc();
        ld_addr   = 32'h0000_4000;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("ldc_popping", 64'(ld_conflict), 64'd1);
        drain();
        ld_addr = '0;

        // Two byte stores to the same word
        mem_ready = 1'b0;
        send(2'd0, 32'h0000_5000, 32'h11);
        send(2'd0, 32'h0000_5001, 32'h22);
        @(negedge clk);
`ifdef STORE_MERGE_EN
        chk("merge_be",    64'(mem_be),          64'b0011);
        chk("merge_wdata", 64'(mem_wdata[15:0]), 64'h2211);
`else
        chk("nomerge_be",    64'(mem_be),    64'b0001);
        chk("nomerge_wdata", 64'(mem_wdata), 64'h1111_1111);
`endif
        cyc();
        mem_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_valid && mem_ready) pops++;
        end
`ifdef STORE_MERGE_EN
        chk("merge_entries", 64'(pops), 64'd1);
`else
        chk("nomerge_entries", 64'(pops), 64'd2);
`endif
        cyc();

        // Back-to-back faults, including a dword on the 32-bit path
        st_valid = 1'b1; st_size = 2'd1; st_addr = 32'h6001;
        cyc();
        st_size = 2'd2; st_addr = 32'h6002;
        @(negedge clk);
        chk("f1_valid", 64'(exc_valid), 64'd1);
        chk("f1_addr",  64'(exc_addr),  64'h6001);
        cyc();
        st_size = 2'd3; st_addr = 32'h7000;
        @(negedge clk);
        chk("f2_valid", 64'(exc_valid), 64'd1);
        chk("f2_addr",  64'(exc_addr),  64'h6002);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("f3_addr",  64'(exc_addr),  64'h7000);
        @(negedge clk);
        chk("f_end",    64'(exc_valid), 64'd0);

        // Reset mid-operation discards queued stores
        cyc();
        mem_ready = 1'b0;
        send(2'd2, 32'h8000, 32'h1);
        send(2'd2, 32'h8004, 32'h2);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 64'(mem_valid), 64'd0);
        chk("mrst_idle",  64'(idle),      64'd1);
        chk("mrst_ready", 64'(st_ready),  64'd1);
        chk("mrst_exc",   64'(exc_addr),  64'd0);
        cyc();
        reset = 1'b0;
        mem_ready = 1'b1;
        send(2'd0, 32'h9002, 32'h77);
        @(negedge clk);
        chk("post_rst_be", 64'(mem_be), 64'b0100);
        drain();

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
